// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: sequences six march elements over addresses 0..LAST_ADDR
// and compares read data through a 2-stage pipeline matching the memory read latency.
module mbist_march_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned LAST_ADDR  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ONES     = {DATA_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        StIdle, StSetup, StRead, StWrite, StDrain, StDone
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  drain_q, drain_d;
    logic                  accept;
    logic                  at_end;
    logic [ADDR_WIDTH-1:0] addr_step;

    logic                  v1_q, v2_q;
    logic [ADDR_WIDTH-1:0] a1_q, a2_q;
    logic [DATA_WIDTH-1:0] e1_q, e2_q;
    logic                  fail_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_exp_q;

    // Element table: M0..M5 of March C-.
    function automatic logic elem_up(input logic [2:0] e);
        return (e == 3'd0) || (e == 3'd1) || (e == 3'd2) || (e == 3'd5);
    endfunction

    function automatic logic elem_has_read(input logic [2:0] e);
        return e != 3'd0;
    endfunction

    function automatic logic elem_has_write(input logic [2:0] e);
        return e != 3'd5;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] elem_wval(input logic [2:0] e);
        return ((e == 3'd1) || (e == 3'd3)) ? ONES : '0;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] elem_rexp(input logic [2:0] e);
        return ((e == 3'd2) || (e == 3'd4)) ? ONES : '0;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] elem_start(input logic [2:0] e);
        return elem_up(e) ? '0 : LAST;
    endfunction

    always_comb begin
        at_end    = elem_up(elem_q) ? (addr_q == LAST) : (addr_q == '0);
        addr_step = elem_up(elem_q) ? (addr_q + ADDR_ONE) : (addr_q - ADDR_ONE);
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StSetup;
                    elem_d  = 3'd0;
                    addr_d  = '0;
                    accept  = 1'b1;
                end
            end
            StSetup: state_d = elem_has_read(elem_q) ? StRead : StWrite;
            StRead: begin
                if (elem_has_write(elem_q)) begin
                    state_d = StWrite;
                end else if (at_end) begin
                    state_d = StDrain;
                    drain_d = 1'b0;
                end else begin
                    addr_d = addr_step;
                end
            end
            StWrite: begin
                if (at_end) begin
                    elem_d  = elem_q + 3'd1;
                    addr_d  = elem_start(elem_q + 3'd1);
                    state_d = StSetup;
                end else begin
                    addr_d  = addr_step;
                    state_d = elem_has_read(elem_q) ? StRead : StWrite;
                end
            end
            StDrain: begin
                if (drain_q) begin
                    state_d = StDone;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory-side outputs are purely state-decoded so reset forces them low immediately.
    always_comb begin
        busy           = (state_q == StSetup) || (state_q == StRead) ||
                         (state_q == StWrite) || (state_q == StDrain);
        done           = (state_q == StDone);
        mem_write_read = (state_q == StWrite);
        mem_address    = '0;
        mem_wdata      = '0;
        if ((state_q == StSetup) || (state_q == StRead) || (state_q == StWrite)) begin
            mem_address = addr_q;
            mem_wdata   = elem_wval(elem_q);
        end
        fail      = fail_q;
        fail_addr = fail_addr_q;
        fail_data = fail_data_q;
        fail_exp  = fail_exp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            drain_q     <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            a1_q        <= '0;
            a2_q        <= '0;
            e1_q        <= '0;
            e2_q        <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_exp_q  <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            v1_q    <= (state_q == StRead);
            a1_q    <= addr_q;
            e1_q    <= elem_rexp(elem_q);
            v2_q    <= v1_q;
            a2_q    <= a1_q;
            e2_q    <= e1_q;
            if (accept) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_data_q <= '0;
                fail_exp_q  <= '0;
            end else if (v2_q && (mem_rdata != e2_q) && !fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= a2_q;
                fail_data_q <= mem_rdata;
                fail_exp_q  <= e2_q;
            end
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: memory model with injectable faults, element-table reference
// schedule and a per-cycle compare process.
module tb_mbist_march_ctrl;

    localparam int N    = 16;
    localparam int BUSY = 10 * N + 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, fail, mem_write_read;
    logic [3:0] fail_addr, mem_address;
    logic [7:0] fail_data, fail_exp, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LAST_ADDR(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_data(fail_data), .fail_exp(fail_exp),
        .mem_write_read(mem_write_read), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory: write data captured one cycle early, 2-cycle read latency.
    // fault_mode 1: addr 5 bit 3 stuck-at-1; 2: addr 7 bit 1 latches to 1 once
    // addr 6 and addr 8 both hold bit 1 = 1.
    logic [7:0] mem [16];
    logic [7:0] wdq, rd1, rd2;
    bit         cf;
    bit         clr = 1'b0;
    int         fault_mode = 0;

    function automatic logic [7:0] rval(input logic [3:0] a);
        logic [7:0] v;
        v = mem[a];
        if (fault_mode == 1 && a == 4'd5) v = v | 8'h08;
        if (fault_mode == 2 && a == 4'd7 && cf) v = v | 8'h02;
        return v;
    endfunction

    always @(posedge clk) begin
        wdq <= mem_wdata;
        rd1 <= rval(mem_address);
        rd2 <= rd1;
        if (clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            cf <= 1'b0;
        end else begin
            if (mem_write_read) mem[mem_address] <= wdq;
            if (mem[8][1] && mem[6][1]) cf <= 1'b1;
        end
    end
    assign mem_rdata = rd2;

    // Reference schedule built from the March C- element table.
    typedef struct {
        bit         we;
        bit         rd;
        bit         care;
        int         addr;
        logic [7:0] wd;
        logic [7:0] exp;
    } op_t;
    op_t sched[$];

    function automatic void build_sched();
        bit         up;
        logic [7:0] wv, rv;
        int         a;
        sched.delete();
        for (int e = 0; e < 6; e++) begin
            up = (e == 0 || e == 1 || e == 2 || e == 5);
            wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
            rv = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            sched.push_back('{we: 0, rd: 0, care: 1, addr: up ? 0 : N - 1, wd: wv, exp: 0});
            for (int i = 0; i < N; i++) begin
                a = up ? i : N - 1 - i;
                if (e != 0) sched.push_back('{we: 0, rd: 1, care: 1, addr: a, wd: wv, exp: rv});
                if (e != 5) sched.push_back('{we: 1, rd: 0, care: 1, addr: a, wd: wv, exp: 0});
            end
        end
        for (int d = 0; d < 2; d++) sched.push_back('{we: 0, rd: 0, care: 0, addr: 0, wd: 0, exp: 0});
    endfunction

    // Model state for the running test.
    bit         mon_on = 1'b0;
    bit         run_done = 1'b0;
    int         idx = 0;
    int         bcnt = 0;
    bit         m_fail;
    logic [3:0] m_addr;
    logic [7:0] m_data, m_exp;

    always @(negedge clk) begin
        if (busy) bcnt++;
        if (mon_on) begin
            if (idx < sched.size()) begin
                chk("busy", {31'd0, busy}, 1);
                chk("done", {31'd0, done}, 0);
                chk("mem_write_read", {31'd0, mem_write_read}, {31'd0, sched[idx].we});
                if (sched[idx].care) begin
                    chk("mem_address", {28'd0, mem_address}, sched[idx].addr);
                    chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, sched[idx].wd});
                end
                chk("fail", {31'd0, fail}, {31'd0, m_fail});
                chk("fail_addr", {28'd0, fail_addr}, {28'd0, m_addr});
                chk("fail_data", {24'd0, fail_data}, {24'd0, m_data});
                chk("fail_exp", {24'd0, fail_exp}, {24'd0, m_exp});
                if (idx >= 2 && sched[idx-2].rd && !m_fail && mem_rdata !== sched[idx-2].exp) begin
                    m_fail = 1'b1;
                    m_addr = 4'(sched[idx-2].addr);
                    m_data = mem_rdata;
                    m_exp  = sched[idx-2].exp;
                end
                idx++;
            end else begin
                chk("end busy", {31'd0, busy}, 0);
                chk("end done", {31'd0, done}, 1);
                chk("end fail", {31'd0, fail}, {31'd0, m_fail});
                chk("end fail_addr", {28'd0, fail_addr}, {28'd0, m_addr});
                chk("end fail_data", {24'd0, fail_data}, {24'd0, m_data});
                chk("end fail_exp", {24'd0, fail_exp}, {24'd0, m_exp});
                chk("done mem outputs", {23'd0, mem_write_read, mem_address, mem_wdata}, 0);
                mon_on   = 1'b0;
                run_done = 1'b1;
            end
        end
    end

    task automatic launch(input int fm);
        fault_mode = fm;
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        m_fail = 0; m_addr = 0; m_data = 0; m_exp = 0;
        idx = 0; bcnt = 0; run_done = 1'b0; mon_on = 1'b1;
    endtask

    task automatic do_run(input string nm, input int fm, input bit pulse50, input bit exp_f,
                          input int exp_a, input bit chk_de, input int exp_d, input int exp_e);
        bit pulsed;
        pulsed = 1'b0;
        launch(fm);
        for (int c = 0; c < 400 && !run_done; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (pulse50 && !pulsed && idx == 50) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
        end
        start = 1'b0;
        if (!run_done) begin
            chk({nm, " timeout"}, 0, 1);
            mon_on = 1'b0;
        end else begin
            chk({nm, " busy cycles"}, bcnt, BUSY);
            chk({nm, " fail"}, {31'd0, fail}, {31'd0, exp_f});
            if (exp_f) chk({nm, " fail_addr"}, {28'd0, fail_addr}, exp_a);
            if (chk_de) begin
                chk({nm, " fail_data"}, {24'd0, fail_data}, exp_d);
                chk({nm, " fail_exp"}, {24'd0, fail_exp}, exp_e);
            end
        end
    endtask

    initial begin
        build_sched();
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {18'd0, busy, done, fail, mem_write_read, mem_address, mem_wdata}, 0);
        chk("reset fail regs", {12'd0, fail_addr, fail_data, fail_exp}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle after reset", {29'd0, busy, done, fail}, 0);

        do_run("clean", 0, 0, 0, 0, 0, 0, 0);
        do_run("stuck", 1, 0, 1, 5, 1, 8'h08, 8'h00);
        do_run("restart clean", 0, 0, 0, 0, 0, 0, 0);
        do_run("coupling", 2, 0, 1, 7, 1, 8'h02, 8'h00);
        do_run("start ignored", 1, 1, 1, 5, 1, 8'h08, 8'h00);

        // Reset in the middle of M2.
        launch(0);
        for (int c = 0; c < 200 && idx < 60; c++) @(posedge clk);
        #1;
        chk("reached M2", {31'd0, idx >= 60 && idx < 83}, 1);
        mon_on = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk); #1;
        chk("mid reset outputs", {28'd0, busy, done, fail, mem_write_read}, 0);
        chk("mid reset mem", {20'd0, mem_address, mem_wdata}, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no restart after reset", {29'd0, busy, done, fail}, 0);
        do_run("post reset clean", 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
